// File: rtl/rx_frame_pkg.sv
// Shared constants and types for the RX frame deframer: marker words,
// FSM state encoding and error codes.
package rx_frame_pkg;

  localparam logic [15:0] DEF_HEADER_WORD = 16'hDEAD;
  localparam logic [15:0] DEF_ENDER_WORD  = 16'hBEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TSTAMP  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_ENDER   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ENDER = 2'd1;
  localparam logic [1:0] ERR_LINK  = 2'd2;

endpackage

// File: rtl/rx_frame_deframer_sat_counter.sv
// Saturating up-counter used for the good/bad frame statistics.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {CNT_WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/rx_frame_deframer.sv
// Parses header/timestamp/payload/ender frames from one RX lane and emits the
// payload as a framed stream with one cycle of latency; all outputs registered.
//
// state      | meaning
// ST_IDLE    | hunting for a clean header word
// ST_TSTAMP  | next word is the frame timestamp
// ST_PAYLOAD | forwarding PAYLOAD_LEN payload words
// ST_ENDER   | checking the ender word, then back to idle
module rx_frame_deframer
  import rx_frame_pkg::*;
#(
  parameter logic [15:0] HEADER_WORD = DEF_HEADER_WORD,
  parameter logic [15:0] ENDER_WORD  = DEF_ENDER_WORD,
  parameter int          PAYLOAD_LEN = 125,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk_trans,
  input  logic                 rst,
  input  logic [1:0]           rx_syncstatus,
  input  logic [1:0]           rx_datak,
  input  logic [15:0]          rx_parallel_data,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [15:0]          out_timestamp,
  output logic                 out_abort,
  output logic                 frame_done,
  output logic                 frame_good,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] good_frame_count,
  output logic [CNT_WIDTH-1:0] bad_frame_count
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [15:0] ts_nxt, data_nxt;
  logic        valid_nxt, sop_nxt, eop_nxt, abort_nxt, done_nxt, good_nxt;
  logic [1:0]  err_nxt;
  logic        inc_good, inc_bad;
  logic        link_ok;

  assign link_ok = (rx_syncstatus == 2'b11) && (rx_datak == 2'b00);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ts_nxt    = out_timestamp;
    data_nxt  = out_data;
    valid_nxt = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    abort_nxt = 1'b0;
    done_nxt  = 1'b0;
    good_nxt  = frame_good;
    err_nxt   = err_code;
    inc_good  = 1'b0;
    inc_bad   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (link_ok && (rx_parallel_data == HEADER_WORD))
          state_nxt = ST_TSTAMP;
      end
      ST_TSTAMP: begin
        if (link_ok) begin
          ts_nxt    = rx_parallel_data;
          count_nxt = 8'd0;
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (link_ok) begin
          valid_nxt = 1'b1;
          data_nxt  = rx_parallel_data;
          sop_nxt   = (count == 8'd0);
          eop_nxt   = (count == LAST_IDX);
          count_nxt = count + 8'd1;
          if (count == LAST_IDX)
            state_nxt = ST_ENDER;
        end
      end
      ST_ENDER: begin
        if (link_ok) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
          if (rx_parallel_data == ENDER_WORD) begin
            good_nxt = 1'b1;
            err_nxt  = ERR_NONE;
            inc_good = 1'b1;
          end else begin
            good_nxt = 1'b0;
            err_nxt  = ERR_ENDER;
            inc_bad  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Link loss anywhere inside a frame abandons it; no eop is ever issued.
    if ((state != ST_IDLE) && !link_ok) begin
      abort_nxt = 1'b1;
      good_nxt  = 1'b0;
      err_nxt   = ERR_LINK;
      inc_bad   = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_trans or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= 8'd0;
      out_valid     <= 1'b0;
      out_data      <= 16'd0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_timestamp <= 16'd0;
      out_abort     <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      out_valid     <= valid_nxt;
      out_data      <= data_nxt;
      out_sop       <= sop_nxt;
      out_eop       <= eop_nxt;
      out_timestamp <= ts_nxt;
      out_abort     <= abort_nxt;
      frame_done    <= done_nxt;
      frame_good    <= good_nxt;
      err_code      <= err_nxt;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk   (clk_trans),
    .rst   (rst),
    .inc   (inc_good),
    .count (good_frame_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_cnt (
    .clk   (clk_trans),
    .rst   (rst),
    .inc   (inc_bad),
    .count (bad_frame_count)
  );

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Directed bench for rx_frame_deframer: nominal, bad ender, link loss, dirty
// header, back-to-back frames, mid-frame reset and 2-bit counter saturation.
module tb_rx_frame_deframer;

  logic        clk_trans = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rx_syncstatus = 2'b11;
  logic [1:0]  rx_datak = 2'b00;
  logic [15:0] rx_parallel_data = 16'h0000;

  logic        out_valid, out_sop, out_eop, out_abort, frame_done, frame_good;
  logic [15:0] out_data, out_timestamp;
  logic [1:0]  err_code;
  logic [15:0] good_frame_count, bad_frame_count;

  logic        s_valid, s_sop, s_eop, s_abort, s_done, s_good;
  logic [15:0] s_data, s_ts;
  logic [1:0]  s_err;
  logic [1:0]  s_good_cnt, s_bad_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  int n_valid = 0, n_sop = 0, n_eop = 0, n_abort = 0, n_done = 0, n_overlap = 0;
  logic [15:0] sop_data = 16'h0, eop_data = 16'h0, sop_ts = 16'h0;
  logic        last_good = 1'b0;
  logic [1:0]  last_err = 2'd0;
  int v0, s0, e0, a0, d0;

  always #5 clk_trans = ~clk_trans;

  rx_frame_deframer dut (
    .clk_trans        (clk_trans),
    .rst              (rst),
    .rx_syncstatus    (rx_syncstatus),
    .rx_datak         (rx_datak),
    .rx_parallel_data (rx_parallel_data),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .out_timestamp    (out_timestamp),
    .out_abort        (out_abort),
    .frame_done       (frame_done),
    .frame_good       (frame_good),
    .err_code         (err_code),
    .good_frame_count (good_frame_count),
    .bad_frame_count  (bad_frame_count)
  );

  rx_frame_deframer #(.CNT_WIDTH(2)) dut_sat (
    .clk_trans        (clk_trans),
    .rst              (rst),
    .rx_syncstatus    (rx_syncstatus),
    .rx_datak         (rx_datak),
    .rx_parallel_data (rx_parallel_data),
    .out_valid        (s_valid),
    .out_data         (s_data),
    .out_sop          (s_sop),
    .out_eop          (s_eop),
    .out_timestamp    (s_ts),
    .out_abort        (s_abort),
    .frame_done       (s_done),
    .frame_good       (s_good),
    .err_code         (s_err),
    .good_frame_count (s_good_cnt),
    .bad_frame_count  (s_bad_cnt)
  );

  always @(negedge clk_trans) begin
    if (out_valid) n_valid++;
    if (out_sop) begin
      n_sop++;
      sop_data = out_data;
      sop_ts   = out_timestamp;
    end
    if (out_eop) begin
      n_eop++;
      eop_data = out_data;
    end
    if (out_abort) begin
      n_abort++;
      last_err = err_code;
    end
    if (frame_done) begin
      n_done++;
      last_good = frame_good;
      last_err  = err_code;
    end
    if (out_valid && out_abort) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] sync = 2'b11,
                      input logic [1:0] k = 2'b00);
    rx_parallel_data = d;
    rx_syncstatus    = sync;
    rx_datak         = k;
    @(posedge clk_trans);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'h0000);
  endtask

  // lose_at >= 0 drops sync on that payload word and stops the frame there.
  task automatic frame(input logic [15:0] ts, input logic [15:0] ender, input int lose_at);
    send(16'hDEAD);
    send(ts);
    for (int i = 0; i < 125; i++) begin
      if (i == lose_at) begin
        send(16'(i), 2'b01);
        return;
      end
      send(16'(i));
    end
    send(ender);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic snap();
    v0 = n_valid; s0 = n_sop; e0 = n_eop; a0 = n_abort; d0 = n_done;
  endtask

  initial begin
    idle(2);
    chk("reset_outs", {out_valid, out_sop, out_eop, out_abort, frame_done,
                       frame_good, err_code, out_data}, 0);
    chk("reset_ts", out_timestamp, 0);
    chk("reset_cnts", {good_frame_count, bad_frame_count}, 0);
    rst = 1'b0;
    idle(2);

    // nominal frame
    snap();
    frame(16'h000A, 16'hBEEF, -1);
    idle(2);
    chk("nom_valid", n_valid - v0, 125);
    chk("nom_sop", n_sop - s0, 1);
    chk("nom_eop", n_eop - e0, 1);
    chk("nom_sop_data", sop_data, 16'h0000);
    chk("nom_eop_data", eop_data, 16'h007C);
    chk("nom_ts", sop_ts, 16'h000A);
    chk("nom_done", n_done - d0, 1);
    chk("nom_good_err", {last_good, last_err}, {1'b1, 2'd0});
    chk("nom_good_cnt", good_frame_count, 1);
    chk("nom_bad_cnt", bad_frame_count, 0);

    // bad ender then nominal
    do_reset();
    snap();
    frame(16'h000A, 16'h1234, -1);
    idle(2);
    chk("bend_done", n_done - d0, 1);
    chk("bend_good_err", {last_good, last_err}, {1'b0, 2'd1});
    chk("bend_bad_cnt", bad_frame_count, 1);
    chk("bend_good_cnt0", good_frame_count, 0);
    frame(16'h000A, 16'hBEEF, -1);
    idle(2);
    chk("bend_next_good", {last_good, good_frame_count}, {1'b1, 16'd1});

    // link loss on payload word 50
    do_reset();
    snap();
    frame(16'h0020, 16'hBEEF, 50);
    idle(3);
    chk("loss_valid", n_valid - v0, 50);
    chk("loss_abort", n_abort - a0, 1);
    chk("loss_err", last_err, 2'd2);
    chk("loss_eop", n_eop - e0, 0);
    chk("loss_done", n_done - d0, 0);
    chk("loss_overlap", n_overlap, 0);
    chk("loss_bad_cnt", bad_frame_count, 1);
    frame(16'h0021, 16'hBEEF, -1);
    idle(2);
    chk("loss_next_good", {last_good, good_frame_count}, {1'b1, 16'd1});

    // header with datak set is ignored
    snap();
    send(16'hDEAD, 2'b11, 2'b01);
    send(16'h000A);
    send(16'h0001);
    send(16'hBEEF);
    idle(2);
    chk("dk_outputs", (n_valid - v0) + (n_done - d0) + (n_abort - a0), 0);
    chk("dk_cnts", {good_frame_count, bad_frame_count}, {16'd1, 16'd1});

    // back-to-back frames with zero gap
    do_reset();
    snap();
    frame(16'h0010, 16'hBEEF, -1);
    chk("b2b_ts1", sop_ts, 16'h0010);
    frame(16'h0011, 16'hBEEF, -1);
    idle(2);
    chk("b2b_sop", n_sop - s0, 2);
    chk("b2b_eop", n_eop - e0, 2);
    chk("b2b_ts2", sop_ts, 16'h0011);
    chk("b2b_good_cnt", good_frame_count, 2);

    // reset asserted at payload word 60
    send(16'hDEAD);
    send(16'h0030);
    for (int i = 0; i < 60; i++) send(16'(i));
    rst = 1'b1;
    #1;
    chk("mrst_outs", {out_valid, out_sop, out_eop, out_abort, frame_done,
                      frame_good, err_code, out_data}, 0);
    chk("mrst_ts", out_timestamp, 0);
    chk("mrst_cnts", {good_frame_count, bad_frame_count}, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    snap();
    frame(16'h0031, 16'hBEEF, -1);
    idle(2);
    chk("mrst_next", {last_good, good_frame_count, 16'(n_sop - s0)}, {1'b1, 16'd1, 16'd1});

    // saturation of 2-bit counters
    do_reset();
    for (int f = 0; f < 5; f++) begin
      frame(16'(f), 16'h1234, -1);
      idle(1);
      if (f == 2) chk("sat_after3", s_bad_cnt, 3);
      if (f == 3) chk("sat_after4", s_bad_cnt, 3);
    end
    idle(1);
    chk("sat_after5", s_bad_cnt, 3);
    chk("sat_good", s_good_cnt, 0);
    chk("wide_bad5", bad_frame_count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
